// File: rtl/timer_multi.sv
// Multi-channel down-counting timer peripheral for the PICO16a 16-bit bus.
// Optional macro TIMER_CASCADE_EN: channel k>0 may tick from channel k-1's expiry.
module timer_multi #(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int ADRS_W  = 6
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADRS_W-1:0] adrs,
    input  logic [15:0]       from_cpu,
    output logic [15:0]       to_cpu,
    output logic              int_req
);
    localparam int CH_W = ADRS_W - 3;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [CH_W-1:0] ch_idx;
    logic [2:0]      reg_idx;
    logic            bus_wr;
    logic [15:0]     rd_word [N_CH];
    logic [N_CH-1:0] irq_vec;
    logic [15:0]     rdata;

    assign ch_idx  = adrs[ADRS_W-1:3];
    assign reg_idx = adrs[2:0];
    assign bus_wr  = cs & we;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t             state, state_nxt;
        logic [CNT_W-1:0]   reload, counter, capture;
        logic [PRESC_W-1:0] presc, pcnt;
        logic               auto_rl, ie, pend, cascade;
        logic               sel, wr_reload_hi, wr_reload_lo, wr_ctrl, wr_int, wr_presc;
        logic               load, cap_strobe, own_tick, tick, expire;
        logic [31:0]        cap_ext;
        logic [15:0]        presc_ext, rd;

        assign sel          = bus_wr & (ch_idx == CH_W'(k));
        assign wr_reload_hi = sel & (reg_idx == 3'd0);
        assign wr_reload_lo = sel & (reg_idx == 3'd1);
        assign wr_ctrl      = sel & (reg_idx == 3'd2);
        assign wr_int       = sel & (reg_idx == 3'd4);
        assign wr_presc     = sel & (reg_idx == 3'd5);
        assign load         = wr_ctrl & from_cpu[2];
        assign cap_strobe   = wr_ctrl & from_cpu[3];
        assign own_tick     = (pcnt == presc);

`ifdef TIMER_CASCADE_EN
        logic casc_tick;
        if (k > 0) begin : g_casc
            assign casc_tick = g_ch[k-1].expire;
        end else begin : g_casc0
            assign casc_tick = 1'b0;
        end

        always_ff @(posedge cpu_clk or negedge rst) begin
            if (!rst)
                cascade <= 1'b0;
            else if (wr_ctrl)
                cascade <= (k > 0) && from_cpu[5];
        end

        assign tick = (state == RUN) & (cascade ? casc_tick : own_tick);
`else
        assign cascade = 1'b0;
        assign tick    = (state == RUN) & own_tick;
`endif

        // Load beats a same-edge tick, so a loaded counter never expires on that edge.
        assign expire = tick & ~load & (counter <= CNT_W'(1));

        always_ff @(posedge cpu_clk or negedge rst) begin
            if (!rst)
                state <= IDLE;
            else
                state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            if (wr_ctrl)
                state_nxt = from_cpu[0] ? RUN : IDLE;
            else if (expire && !auto_rl)
                state_nxt = IDLE;
        end

        always_ff @(posedge cpu_clk or negedge rst) begin
            if (!rst) begin
                reload  <= '0;
                counter <= '0;
                capture <= '0;
                presc   <= '0;
                pcnt    <= '0;
                auto_rl <= 1'b0;
                ie      <= 1'b0;
                pend    <= 1'b0;
            end else begin
                if (wr_reload_hi) reload[CNT_W-1:16] <= from_cpu[CNT_W-17:0];
                if (wr_reload_lo) reload[15:0] <= from_cpu;
                if (wr_ctrl) begin
                    auto_rl <= from_cpu[1];
                    ie      <= from_cpu[4];
                end
                if (wr_presc) presc <= from_cpu[PRESC_W-1:0];
                if (cap_strobe) capture <= counter;

                if (load || state == IDLE || cascade || own_tick)
                    pcnt <= '0;
                else
                    pcnt <= pcnt + PRESC_W'(1);

                if (load)
                    counter <= reload;
                else if (expire)
                    counter <= auto_rl ? reload : '0;
                else if (tick)
                    counter <= counter - CNT_W'(1);

                // A clear that coincides with an expiry loses to the new event.
                if (expire)
                    pend <= 1'b1;
                else if (wr_int && from_cpu[0])
                    pend <= 1'b0;
            end
        end

        always_comb begin
            cap_ext = '0;
            cap_ext[CNT_W-1:0] = capture;
            presc_ext = '0;
            presc_ext[PRESC_W-1:0] = presc;
            rd = '0;
            case (reg_idx)
                3'd0:    rd = cap_ext[31:16];
                3'd1:    rd = cap_ext[15:0];
                3'd2:    rd = {10'b0, cascade, ie, 2'b00, auto_rl, state == RUN};
                3'd3:    rd = {13'b0, pend, counter == '0, state == RUN};
                3'd4:    rd = {15'b0, pend};
                3'd5:    rd = presc_ext;
                default: rd = '0;
            endcase
        end

        assign rd_word[k] = rd;
        assign irq_vec[k] = pend & ie;
    end

    // Channel indices past N_CH match no channel and therefore read 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++)
            if (ch_idx == CH_W'(i))
                rdata = rd_word[i];
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst)
            to_cpu <= '0;
        else
            to_cpu <= rdata;
    end

    assign int_req = |irq_vec;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed register/corner steps plus
// randomized one-shot/auto-reload runs compared against an arithmetic timing model.
module tb_timer_multi;
    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [5:0]  adrs;
    logic [15:0] from_cpu;
    logic [15:0] to_cpu;
    logic        int_req;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned e0       = 0;
    logic [15:0] rd_val;

    timer_multi #(.N_CH(2), .CNT_W(32), .PRESC_W(8), .ADRS_W(6)) dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .adrs    (adrs),
        .from_cpu(from_cpu),
        .to_cpu  (to_cpu),
        .int_req (int_req)
    );

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int ch, input int r, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; adrs = 6'(ch * 8 + r); from_cpu = d;
        @(posedge cpu_clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [15:0] d);
        adrs = 6'(ch * 8 + r);
        @(posedge cpu_clk); #1;
        d = to_cpu;
    endtask

    // Positions the bench so the next bus access lands on edge e0+k.
    task automatic wait_until(input int k);
        int guard = 0;
        while (int'(cyc - e0) < k - 1 && guard < 1000) begin
            @(posedge cpu_clk); #1;
            guard++;
        end
        if (int'(cyc - e0) != k - 1) begin
            n_fail++;
            $display("[TB] FAIL wait_until: cycle %0d required %0d", int'(cyc - e0), k - 1);
        end
    endtask

    task automatic stop_all();
        for (int c = 0; c < 2; c++) bus_write(c, 2, 16'h0000);
        for (int c = 0; c < 2; c++) bus_write(c, 4, 16'h0001);
    endtask

    // Reference model: after a load at edge e0, the counter sees one tick every
    // presc+1 edges; m is the number of edges elapsed since the load.
    function automatic int unsigned n_expire(input int unsigned rl, input int unsigned p);
        return ((rl == 0) ? 1 : rl) * (p + 1);
    endfunction

    function automatic logic [31:0] exp_counter(input int unsigned rl, input int unsigned p,
                                                input bit au, input int m);
        int unsigned t = int'(m) / (p + 1);
        if (rl == 0) return 32'd0;
        if (!au) return (t >= rl) ? 32'd0 : rl - t;
        return rl - (t % rl);
    endfunction

    function automatic bit exp_pend(input int unsigned rl, input int unsigned p, input int m);
        return m >= int'(n_expire(rl, p));
    endfunction

    function automatic logic [15:0] exp_status(input int unsigned rl, input int unsigned p,
                                               input bit au, input int m);
        bit running = au ? 1'b1 : (m < int'(n_expire(rl, p)));
        return {13'b0, exp_pend(rl, p, m), exp_counter(rl, p, au, m) == 0, running};
    endfunction

    task automatic apply_stimulus(input int ch, input logic [31:0] rl, input int unsigned p,
                                  input bit au, input bit ie);
        logic [15:0] d, ctrl;
        logic [31:0] cap;
        int span, mc;
        stop_all();
        bus_write(ch, 5, 16'(p));
        bus_write(ch, 0, rl[31:16]);
        bus_write(ch, 1, rl[15:0]);
        ctrl = {11'b0, ie, 1'b0, 1'b1, au, 1'b1};
        bus_write(ch, 2, ctrl);
        e0 = cyc;
        span = int'(n_expire(rl, p)) + int'(p) + 3;
        for (int j = 1; j <= span; j++) begin
            bus_read(ch, 3, d);
            check_output("status", 32'(d), 32'(exp_status(rl, p, au, j - 1)));
            check_output("int_req", 32'(int_req), 32'(ie & exp_pend(rl, p, j)));
        end
        bus_write(ch, 2, {11'b0, ie, 1'b1, 1'b0, au, 1'b1});
        mc = int'(cyc - e0);
        cap = exp_counter(rl, p, au, mc - 1);
        bus_read(ch, 1, d);
        check_output("capture_lo", 32'(d), 32'(cap[15:0]));
        bus_read(ch, 0, d);
        check_output("capture_hi", 32'(d), 32'(cap[31:16]));
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; we = 1'b0; adrs = '0; from_cpu = '0;
        #2;
        check_output("reset_int_req", 32'(int_req), 32'd0);
        check_output("reset_to_cpu", 32'(to_cpu), 32'd0);
        repeat (3) @(posedge cpu_clk);
        #1 rst = 1'b1;

        bus_read(0, 3, rd_val); check_output("post_reset_status0", 32'(rd_val), 32'h0002);
        bus_read(1, 3, rd_val); check_output("post_reset_status1", 32'(rd_val), 32'h0002);
        bus_read(0, 2, rd_val); check_output("post_reset_ctrl0", 32'(rd_val), 32'h0000);

        bus_write(1, 5, 16'h00A5);
        bus_read(1, 5, rd_val); check_output("presc_rb", 32'(rd_val), 32'h00A5);
        bus_write(1, 5, 16'hFF3C);
        bus_read(1, 5, rd_val); check_output("presc_width", 32'(rd_val), 32'h003C);
        bus_write(1, 2, 16'h003A);
        bus_read(1, 2, rd_val);
`ifdef TIMER_CASCADE_EN
        check_output("ctrl_rb", 32'(rd_val), 32'h0032);
`else
        check_output("ctrl_rb", 32'(rd_val), 32'h0012);
`endif
        bus_write(1, 2, 16'h0000);

        apply_stimulus(0, 32'd5, 0, 1'b0, 1'b1);
        bus_read(0, 3, rd_val);
        check_output("oneshot_final", 32'(rd_val), 32'h0006);
        apply_stimulus(1, 32'd3, 1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(int'($urandom_range(0, 1)), 32'($urandom_range(0, 12)),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
        end

        // Auto-reload ch1 expires at edges 6, 12, 18; clear races against edge 12.
        stop_all();
        bus_write(1, 5, 16'd1);
        bus_write(1, 0, 16'd0);
        bus_write(1, 1, 16'd3);
        bus_write(1, 2, 16'h0017);
        e0 = cyc;
        wait_until(8);
        bus_write(1, 4, 16'h0001);
        bus_read(1, 4, rd_val); check_output("w1c_clear", 32'(rd_val), 32'h0000);
        wait_until(12);
        bus_write(1, 4, 16'h0001);
        check_output("w1c_race_irq", 32'(int_req), 32'd1);
        bus_read(1, 4, rd_val); check_output("w1c_race_pend", 32'(rd_val), 32'h0001);
        bus_write(1, 4, 16'h0001);
        check_output("w1c_irq_drop", 32'(int_req), 32'd0);
        bus_read(1, 4, rd_val); check_output("w1c_pend_drop", 32'(rd_val), 32'h0000);

        stop_all();
        bus_write(0, 5, 16'd0);
        bus_write(0, 0, 16'h0001);
        bus_write(0, 1, 16'h0005);
        bus_write(0, 2, 16'h0005);
        e0 = cyc;
        wait_until(11);
        bus_write(0, 2, 16'h0009);
        bus_read(0, 0, rd_val); check_output("cap_hi", 32'(rd_val), 32'h0000);
        bus_read(0, 1, rd_val); check_output("cap_lo", 32'(rd_val), 32'hFFFB);
        bus_read(0, 3, rd_val); check_output("cap_status", 32'(rd_val), 32'h0001);

        stop_all();
        bus_write(0, 0, 16'd0); bus_write(0, 1, 16'd7); bus_write(0, 2, 16'h0004);
        bus_write(1, 0, 16'd0); bus_write(1, 1, 16'd9); bus_write(1, 2, 16'h0004);
        bus_write(3, 2, 16'h0015);
        bus_write(3, 1, 16'h0001);
        bus_write(2, 2, 16'h0017);
        bus_write(0, 6, 16'hFFFF);
        bus_write(0, 7, 16'hFFFF);
        bus_read(3, 2, rd_val); check_output("oor_ctrl3", 32'(rd_val), 32'h0000);
        bus_read(3, 3, rd_val); check_output("oor_status3", 32'(rd_val), 32'h0000);
        bus_read(2, 3, rd_val); check_output("oor_status2", 32'(rd_val), 32'h0000);
        bus_read(0, 6, rd_val); check_output("rsv_reg6", 32'(rd_val), 32'h0000);
        bus_read(0, 7, rd_val); check_output("rsv_reg7", 32'(rd_val), 32'h0000);
        bus_read(0, 3, rd_val); check_output("oor_keep_status0", 32'(rd_val), 32'h0000);
        bus_read(1, 3, rd_val); check_output("oor_keep_status1", 32'(rd_val), 32'h0000);
        bus_read(1, 2, rd_val); check_output("oor_keep_ctrl1", 32'(rd_val), 32'h0000);
        check_output("oor_int_req", 32'(int_req), 32'd0);

        // Ch1 armed with cascade first; ch0 expires every 4 edges from e0.
        stop_all();
        bus_write(0, 5, 16'd0); bus_write(0, 0, 16'd0); bus_write(0, 1, 16'd4);
        bus_write(1, 5, 16'd0); bus_write(1, 0, 16'd0); bus_write(1, 1, 16'd2);
        bus_write(1, 2, 16'h0027);
        bus_write(0, 2, 16'h0007);
        e0 = cyc;
        wait_until(8);
        bus_read(1, 4, rd_val);
`ifdef TIMER_CASCADE_EN
        check_output("casc_before", 32'(rd_val), 32'h0000);
`else
        check_output("casc_before", 32'(rd_val), 32'h0001);
`endif
        bus_read(1, 4, rd_val); check_output("casc_at8", 32'(rd_val), 32'h0001);
        bus_read(1, 2, rd_val);
`ifdef TIMER_CASCADE_EN
        check_output("casc_ctrl", 32'(rd_val), 32'h0023);
`else
        check_output("casc_ctrl", 32'(rd_val), 32'h0003);
`endif

        stop_all();
        bus_write(1, 0, 16'd0); bus_write(1, 1, 16'd100); bus_write(1, 2, 16'h0017);
        bus_write(0, 5, 16'd0); bus_write(0, 0, 16'd0); bus_write(0, 1, 16'd2);
        bus_write(0, 2, 16'h0015);
        e0 = cyc;
        wait_until(4);
        check_output("pre_reset_irq", 32'(int_req), 32'd1);
        #3 rst = 1'b0;
        #1;
        check_output("midrst_int_req", 32'(int_req), 32'd0);
        check_output("midrst_to_cpu", 32'(to_cpu), 32'd0);
        for (int c = 0; c < 2; c++) begin
            adrs = 6'(c * 8 + 3);
            @(posedge cpu_clk); #1;
            check_output("midrst_status", 32'(to_cpu), 32'd0);
        end
        rst = 1'b1;
        bus_read(0, 3, rd_val); check_output("rst_status0", 32'(rd_val), 32'h0002);
        bus_read(1, 3, rd_val); check_output("rst_status1", 32'(rd_val), 32'h0002);
        bus_read(0, 4, rd_val); check_output("rst_pend0", 32'(rd_val), 32'h0000);
        bus_read(1, 2, rd_val); check_output("rst_ctrl1", 32'(rd_val), 32'h0000);
        check_output("rst_int_req", 32'(int_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
